// File: rtl/uart_cmd_decoder.sv
// UART byte-stream to RAM command decoder: 'W'/'R' frames, timeout, error codes.
// Optional trailing XOR checksum byte when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_decoder #(
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Cmd_Valid,
    input  logic              i_Cmd_Ready,
    output logic              o_Cmd_Write,
    output logic [ADDR_W-1:0] o_Cmd_Addr,
    output logic [15:0]       o_Cmd_Data,
    output logic              o_Err,
    output logic [1:0]        o_Err_Code
);

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]  CMD_W   = 8'h57;
    localparam logic [7:0]  CMD_R   = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_DATA_H,
        S_DATA_L,
`ifdef UART_CMD_CHECKSUM_EN
        S_CHK,
`endif
        S_ISSUE
    } state_t;

    state_t      state;
    logic        is_write;
    logic [15:0] addr;
    logic [15:0] data;
    logic [23:0] cnt;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    logic        hs;
    logic        take_idle;
    logic [15:0] addr_now;
    logic [15:0] data_now;

    // A byte in the handshake cycle is treated exactly like an idle byte.
    assign hs        = o_Cmd_Valid && i_Cmd_Ready;
    assign take_idle = i_Rx_DV && (state == S_IDLE || (state == S_ISSUE && hs));
    assign addr_now  = {addr[15:8], i_Rx_Byte};
    assign data_now  = {data[15:8], i_Rx_Byte};

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            is_write    <= 1'b0;
            addr        <= '0;
            data        <= '0;
            cnt         <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            chk         <= '0;
`endif
            o_Cmd_Valid <= 1'b0;
            o_Cmd_Write <= 1'b0;
            o_Cmd_Addr  <= '0;
            o_Cmd_Data  <= '0;
            o_Err       <= 1'b0;
            o_Err_Code  <= 2'b00;
        end else begin
            o_Err <= 1'b0;
            if (state == S_ISSUE && hs) begin
                o_Cmd_Valid <= 1'b0;
                state       <= S_IDLE;
            end
            if (take_idle) begin
                cnt <= '0;
                if (i_Rx_Byte == CMD_W || i_Rx_Byte == CMD_R) begin
                    state    <= S_ADDR_H;
                    is_write <= (i_Rx_Byte == CMD_W);
`ifdef UART_CMD_CHECKSUM_EN
                    chk      <= i_Rx_Byte;
`endif
                end else begin
                    o_Err      <= 1'b1;
                    o_Err_Code <= 2'b00;
                end
            end else if (state == S_ISSUE) begin
                if (i_Rx_DV) begin
                    o_Err      <= 1'b1;
                    o_Err_Code <= 2'b10;
                end
            end else if (i_Rx_DV) begin
                cnt <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                chk <= chk ^ i_Rx_Byte;
`endif
                case (state)
                    S_ADDR_H: begin
                        addr[15:8] <= i_Rx_Byte;
                        state      <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        addr[7:0] <= i_Rx_Byte;
                        if (is_write) begin
                            state <= S_DATA_H;
                        end else begin
`ifdef UART_CMD_CHECKSUM_EN
                            data  <= '0;
                            state <= S_CHK;
`else
                            state       <= S_ISSUE;
                            o_Cmd_Valid <= 1'b1;
                            o_Cmd_Write <= 1'b0;
                            o_Cmd_Addr  <= addr_now[ADDR_W-1:0];
                            o_Cmd_Data  <= '0;
`endif
                        end
                    end
                    S_DATA_H: begin
                        data[15:8] <= i_Rx_Byte;
                        state      <= S_DATA_L;
                    end
                    S_DATA_L: begin
                        data[7:0] <= i_Rx_Byte;
`ifdef UART_CMD_CHECKSUM_EN
                        state     <= S_CHK;
`else
                        state       <= S_ISSUE;
                        o_Cmd_Valid <= 1'b1;
                        o_Cmd_Write <= 1'b1;
                        o_Cmd_Addr  <= addr[ADDR_W-1:0];
                        o_Cmd_Data  <= data_now;
`endif
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    S_CHK: begin
                        if (i_Rx_Byte == chk) begin
                            state       <= S_ISSUE;
                            o_Cmd_Valid <= 1'b1;
                            o_Cmd_Write <= is_write;
                            o_Cmd_Addr  <= addr[ADDR_W-1:0];
                            o_Cmd_Data  <= is_write ? data : 16'h0000;
                        end else begin
                            state      <= S_IDLE;
                            o_Err      <= 1'b1;
                            o_Err_Code <= 2'b11;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                // Mid-frame with no byte this cycle: age the frame.
                if (cnt == TO_LAST) begin
                    state      <= S_IDLE;
                    cnt        <= '0;
                    o_Err      <= 1'b1;
                    o_Err_Code <= 2'b01;
                end else begin
                    cnt <= cnt + 24'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: per-cycle vector table plus
// hand sequences for timeout, reset and (optionally) checksum frames.
module tb_uart_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv = 1'b0;
    logic [7:0]  rx = 8'h00;
    logic        ready = 1'b0;
    logic        valid;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
    logic [1:0]  code;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .ADDR_W(16),
        .TIMEOUT_CLKS(50)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Rx_DV(dv),
        .i_Rx_Byte(rx),
        .o_Cmd_Valid(valid),
        .i_Cmd_Ready(ready),
        .o_Cmd_Write(wr),
        .o_Cmd_Addr(addr),
        .o_Cmd_Data(data),
        .o_Err(err),
        .o_Err_Code(code)
    );

    typedef struct {
        logic        dv;
        logic [7:0]  b;
        logic        rdy;
        logic        v;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        e;
        logic [1:0]  c;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic d_v, logic [7:0] b, logic r, logic v,
                                logic w, logic [15:0] a, logic [15:0] d,
                                logic e, logic [1:0] c);
        vec_t t;
        t.dv = d_v; t.b = b; t.rdy = r; t.v = v; t.w = w;
        t.a = a; t.d = d; t.e = e; t.c = c;
        return t;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b);
        dv = 1'b1;
        rx = b;
        tick();
        dv = 1'b0;
    endtask

    task automatic chk_all(string tag, logic v, logic w, logic [15:0] a,
                           logic [15:0] d, logic e, logic [1:0] c);
        chk({tag, ".valid"}, {15'd0, valid}, {15'd0, v});
        chk({tag, ".write"}, {15'd0, wr}, {15'd0, w});
        chk({tag, ".addr"}, addr, a);
        chk({tag, ".data"}, data, d);
        chk({tag, ".err"}, {15'd0, err}, {15'd0, e});
        chk({tag, ".code"}, {14'd0, code}, {14'd0, c});
    endtask

    initial begin
        int err_at;
        int err_cnt;
        int v_seen;

        tick();
        tick();
        chk_all("reset", 0, 0, 16'h0000, 16'h0000, 0, 2'd0);
        rst = 1'b0;

`ifndef UART_CMD_CHECKSUM_EN
        // write 57 12 34 AB CD with ready high
        vecs.push_back(mk(1, 8'h57, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 8'h12, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 8'h34, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 8'hAB, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 8'hCD, 1, 1, 1, 16'h1234, 16'hABCD, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 16'h1234, 16'hABCD, 0, 0));
        // bad command byte
        vecs.push_back(mk(1, 8'h41, 1, 0, 1, 16'h1234, 16'hABCD, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 16'h1234, 16'hABCD, 0, 0));
        // read 52 00 FF, ready low, overrun byte 60
        vecs.push_back(mk(1, 8'h52, 0, 0, 1, 16'h1234, 16'hABCD, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 1, 16'h1234, 16'hABCD, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 16'h00FF, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 16'h00FF, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 8'h60, 0, 1, 0, 16'h00FF, 16'h0000, 1, 2));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 8'h00, 0, 1, 0, 16'h00FF, 16'h0000, 0, 2));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h00FF, 16'h0000, 0, 2));
        // read 52 AA 55; next frame starts in the handshake cycle
        vecs.push_back(mk(1, 8'h52, 0, 0, 0, 16'h00FF, 16'h0000, 0, 2));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 16'h00FF, 16'h0000, 0, 2));
        vecs.push_back(mk(1, 8'h55, 0, 1, 0, 16'hAA55, 16'h0000, 0, 2));
        vecs.push_back(mk(1, 8'h52, 1, 0, 0, 16'hAA55, 16'h0000, 0, 2));
        vecs.push_back(mk(1, 8'h00, 1, 0, 0, 16'hAA55, 16'h0000, 0, 2));
        vecs.push_back(mk(1, 8'h07, 1, 1, 0, 16'h0007, 16'h0000, 0, 2));
        // bad byte in handshake cycle
        vecs.push_back(mk(1, 8'h41, 1, 0, 0, 16'h0007, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0007, 16'h0000, 0, 0));

        foreach (vecs[i]) begin
            dv = vecs[i].dv;
            rx = vecs[i].b;
            ready = vecs[i].rdy;
            tick();
            chk_all($sformatf("row%0d", i), vecs[i].v, vecs[i].w, vecs[i].a,
                    vecs[i].d, vecs[i].e, vecs[i].c);
        end
        dv = 1'b0;
`else
        ready = 1'b1;
        send(8'h57); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(8'h17);
        chk_all("csum_ok", 1, 1, 16'h1234, 16'hABCD, 0, 0);
        tick();
        chk({"csum_ok.drop"}, {15'd0, valid}, 16'd0);
        send(8'h57); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(8'h18);
        chk_all("csum_bad", 0, 1, 16'h1234, 16'hABCD, 1, 3);
        tick();
        chk({"csum_bad.after"}, {15'd0, valid}, 16'd0);
`endif

        // timeout: 57 12 then idle
        ready = 1'b1;
        send(8'h57);
        send(8'h12);
        err_at = 0;
        err_cnt = 0;
        v_seen = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (err) begin
                err_cnt++;
                if (err_at == 0) err_at = i;
                chk("timeout.code", {14'd0, code}, 16'd1);
            end
            if (valid) v_seen++;
        end
        chk("timeout.cycle", 16'(err_at), 16'd50);
        chk("timeout.pulses", 16'(err_cnt), 16'd1);
        chk("timeout.novalid", 16'(v_seen), 16'd0);

        ready = 1'b0;
        send(8'h52); send(8'h00); send(8'h01);
`ifdef UART_CMD_CHECKSUM_EN
        send(8'h53);
`endif
        chk_all("after_to", 1, 0, 16'h0001, 16'h0000, 0, 1);
        ready = 1'b1;
        tick();
        chk("after_to.drop", {15'd0, valid}, 16'd0);

        // reset mid-frame
        send(8'h57); send(8'h12); send(8'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_mid", 0, 0, 16'h0000, 16'h0000, 0, 0);
        ready = 1'b0;
        send(8'h52); send(8'h12); send(8'h34);
`ifdef UART_CMD_CHECKSUM_EN
        send(8'h74);
`endif
        chk_all("rst_fresh", 1, 0, 16'h1234, 16'h0000, 0, 0);

        // reset while a command is pending
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_issue", 0, 0, 16'h0000, 16'h0000, 0, 0);
        tick();
        chk("rst_issue.stay", {15'd0, valid}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
